// File: rtl/lsu_pkg.sv
// Shared state type, funct3 encodings and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        RD0,
        ISSUE1,
        RD1,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [2:0] lsu_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: lsu_size = 3'd1;
            F3_H, F3_HU: lsu_size = 3'd2;
            default:     lsu_size = 3'd4;
        endcase
    endfunction

    function automatic logic lsu_legal(input logic write, input logic [2:0] funct3);
        if (write)
            lsu_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            lsu_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                        (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory signals of the load/store unit.
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  mem_en;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    // The pipeline and the memory together form the master side; the LSU is the slave.
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: size/split decode, store steering, load merge and extension.
module lsu_align import lsu_pkg::*; (
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata
);

    logic [2:0]  size;
    logic [7:0]  mask;
    logic [63:0] wide_w;
    logic [31:0] shifted;

    always_comb begin
        size     = lsu_size(funct3);
        mask     = (8'd1 << size) - 8'd1;
        split    = ({1'b0, offset} + size) > 3'd4;
        // Mask bits shifted past lane 3 belong to the second word.
        be0      = 4'(mask << offset);
        be1      = 4'(mask >> (3'd4 - {1'b0, offset}));
        wide_w   = {32'b0, wdata} << {offset, 3'b000};
        wdata_lo = wide_w[31:0];
        wdata_hi = wide_w[63:32];
        shifted  = 32'({hi, lo} >> {offset, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: sequences one byte/half/word access at a time, splitting
// accesses that cross a word boundary into two word transactions.
module lsu_ctrl import lsu_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
) (
    input logic       clk,
    input logic       rst_n,
    lsu_ctrl_if.slave bus
);

    lsu_state_t            state;
    logic                  write_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] lo_q;

    logic                  idle;
    logic [2:0]            al_funct3;
    logic [1:0]            al_offset;
    logic [31:0]           al_wdata;
    logic [31:0]           al_lo;
    logic [31:0]           al_hi;
    logic                  split;
    logic [3:0]            be0;
    logic [3:0]            be1;
    logic [31:0]           wdata_lo;
    logic [31:0]           wdata_hi;
    logic [31:0]           load_data;
    logic [ADDR_WIDTH-1:0] word1;
    logic                  unused_addr;

    // While idle the aligner looks at the incoming request so ISSUE0 outputs can be registered on accept.
    always_comb begin
        idle      = (state == IDLE);
        al_funct3 = idle ? bus.req_funct3 : funct3_q;
        al_offset = idle ? bus.req_addr[1:0] : addr_q[1:0];
        al_wdata  = idle ? bus.req_wdata : wdata_q;
        al_lo     = (state == RD0) ? bus.mem_rdata : lo_q;
        al_hi     = (state == RD1) ? bus.mem_rdata : 32'b0;
        word1     = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
    end

    assign unused_addr = ^bus.req_addr[31:ADDR_WIDTH];

    lsu_align u_align (
        .funct3   (al_funct3),
        .offset   (al_offset),
        .wdata    (al_wdata),
        .lo       (al_lo),
        .hi       (al_hi),
        .split    (split),
        .be0      (be0),
        .be1      (be1),
        .wdata_lo (wdata_lo),
        .wdata_hi (wdata_hi),
        .rdata    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            funct3_q       <= 3'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            lo_q           <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'b0;
            bus.resp_err   <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= 4'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= 32'b0;
        end else begin
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'b0;
            bus.resp_err   <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= 4'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= 32'b0;
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid) begin
                        write_q       <= bus.req_write;
                        funct3_q      <= bus.req_funct3;
                        addr_q        <= bus.req_addr[ADDR_WIDTH-1:0];
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (!lsu_legal(bus.req_write, bus.req_funct3)) begin
                            state          <= DONE;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else begin
                            state         <= ISSUE0;
                            bus.mem_en    <= 1'b1;
                            bus.mem_we    <= bus.req_write;
                            bus.mem_be    <= be0;
                            bus.mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus.mem_wdata <= wdata_lo;
                        end
                    end
                end
                ISSUE0: begin
                    if (!write_q) begin
                        state <= RD0;
                    end else if (split) begin
                        state         <= ISSUE1;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_be    <= be1;
                        bus.mem_addr  <= word1;
                        bus.mem_wdata <= wdata_hi;
                    end else begin
                        state          <= DONE;
                        bus.resp_valid <= 1'b1;
                    end
                end
                RD0: begin
                    lo_q <= bus.mem_rdata;
                    if (split) begin
                        state        <= ISSUE1;
                        bus.mem_en   <= 1'b1;
                        bus.mem_be   <= be1;
                        bus.mem_addr <= word1;
                    end else begin
                        state          <= DONE;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= load_data;
                    end
                end
                ISSUE1: begin
                    if (!write_q) begin
                        state <= RD1;
                    end else begin
                        state          <= DONE;
                        bus.resp_valid <= 1'b1;
                    end
                end
                RD1: begin
                    state          <= DONE;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= load_data;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

- Load/store initiator between the pipeline MEM stage and a word-wide, byte-enabled data memory port with one-cycle read latency.
- Accepts one byte/half/word request at a time, encoded by RISC-V funct3.
- Misaligned accesses that cross a word boundary are split into two word transactions; read data is merged and sign- or zero-extended.
- The MEM stage stalls on `req_ready` low.

## Interface

Parameters:
- `DATA_WIDTH`, 32 — data path width; only 32 is supported.
- `ADDR_WIDTH`, 17 — byte-address width of the memory; upper request address bits are ignored.

Ports:
- `clk`  in  1  — single clock; all state is updated on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — request accepted when `req_valid && req_ready`.
- `req_write`  in  1  — 1 = store, 0 = load.
- `req_funct3`  in  3  — access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data, right-aligned.
- `resp_valid`  out  1  — one-cycle completion pulse.
- `resp_rdata`  out  32  — extended load data; 0 for stores and errors.
- `resp_err`  out  1  — illegal funct3; valid with `resp_valid`.
- `mem_en`  out  1  — memory access this cycle.
- `mem_we`  out  1  — write access.
- `mem_be`  out  4  — byte-lane enables.
- `mem_addr`  out  ADDR_WIDTH  — word-aligned address; bits [1:0] are always 0.
- `mem_wdata`  out  32  — lane-steered write data.
- `mem_rdata`  in  32  — read data, valid the cycle after a read `mem_en`.

## Operation

Request capture:
- States: IDLE, ISSUE0, RD0, ISSUE1, RD1, DONE.
- `req_ready = (state == IDLE)`. There is no response backpressure.
- On accept, latch write, funct3, `addr[ADDR_WIDTH-1:0]` and wdata.
- Derived values: offset `o = addr[1:0]`; size `n` = 1, 2 or 4; `split = (o + n > 4)`.

Legality:
- Legal loads: 000, 001, 010, 100, 101.
- Legal stores: 000, 001, 010.
- An illegal request goes IDLE→DONE with no memory access, `resp_err = 1` and `resp_rdata = 0`.

Memory transactions:
- ISSUE0: `mem_en = 1`, `mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}`, `mem_be = (((1<<n)-1) << o)[3:0]`.
- ISSUE1: `mem_addr` = the ISSUE0 word + 4, modulo 2^ADDR_WIDTH (the top word wraps to 0); `mem_be = ((1<<n)-1) >> (4-o)`.
- Store data: the 64-bit value `{32'b0, wdata} << 8*o` is formed. The low half drives `mem_wdata` in ISSUE0 and the high half in ISSUE1. Bytes not covered by `mem_be` are don't-care.

State transitions:
- ISSUE0: next is RD0 for a load. For a store, next is ISSUE1 if split, otherwise DONE.
- RD0: capture `mem_rdata` into `lo`; next is ISSUE1 if split, otherwise DONE.
- ISSUE1: next is RD1 for a load, otherwise DONE.
- RD1: capture `mem_rdata` into `hi`; next is DONE.
- DONE: `resp_valid = 1` for one cycle; next is IDLE.

Load result:
- Form `({hi, lo} >> 8*o)` and keep the low `n` bytes.
- Sign-extend for 000 and 001; zero-extend for 100 and 101.
- `hi` is treated as 0 when not split.

Outputs:
- `mem_en` is low in IDLE, RD0, RD1 and DONE.
- `resp_rdata` and `resp_err` are registered and are 0 outside DONE.

## Timing

Request accepted at edge T. `resp_valid` is high in cycle:
- aligned store: T+2
- split store: T+3
- aligned load: T+3
- split load: T+5
- illegal request: T+1

Next request is accepted at the earliest in the cycle after DONE.

Reset:
- Values while `rst_n` is low: state IDLE; `req_ready = 1`; all other outputs 0.
- Reset mid-request drops the request with no response.
- Reset after ISSUE0 of a split store leaves the first word written.

## Structure

- `lsu_pkg`: state enum `lsu_state_t`; funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`; size decode function.
- Sub-module `lsu_align`, purely combinational, provides:
  - funct3 and offset to size, split flag and both byte-enable masks;
  - store lane steering;
  - load merge and extension.
- `lsu_ctrl` holds the FSM and all registers.

## Test plan

- Aligned SW at addr 0x10000, data 0xDEADBEEF → single write, be=1111, addr 0x10000, resp at T+2, err=0.
- LB at 0x10003 with memory word 0x80xxxxxx → read be=1000, rdata=0xFFFFFF80, resp at T+3. LBU at the same address → 0x00000080.
- Split LW at 0x10002, words 0x44332211 @0x10000 and 0x88776655 @0x10004 → two reads (be 1100, then 0011), rdata=0x66554433, resp at T+5.
- Split SH at 0x1FFFF (top byte) with data 0xA1B2 → write be=1000 data byte B2 @0x1FFFC, then be=0001 byte A1 @0x00000; resp at T+3.
- Illegal funct3: load 011 and store 100 → no `mem_en`, resp_err=1, rdata=0, resp at T+1. Back-to-back `req_valid` is held off by `req_ready` until IDLE.
- Assert `rst_n` low during RD0 of a split load → outputs 0 and `req_ready=1` immediately; no `resp_valid`; the next request completes normally.
